// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and default sizes for the matmul sequencer
package matmul_pkg;

  localparam int DEFAULT_DIM    = 4;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_COMPLETE = 2'b11
  } state_e;

endpackage

// File: rtl/matmul_index_counter.sv
// rtl/matmul_index_counter.sv - nested i/j/k index counter, k fastest, with clear and last flag
module matmul_index_counter
  import matmul_pkg::*;
#(
  parameter int DIM   = DEFAULT_DIM,
  parameter int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] i_o,
  output logic [IDX_W-1:0] j_o,
  output logic [IDX_W-1:0] k_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] MAX = IDX_W'(DIM - 1);

  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic [IDX_W-1:0] i_d, j_d, k_d;

  // The full sweep wraps back to 0/0/0 so the counter idles at the origin.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (en_i) begin
      if (k_q == MAX) begin
        k_d = '0;
        if (j_q == MAX) begin
          j_d = '0;
          i_d = (i_q == MAX) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign k_o    = k_q;
  assign last_o = (i_q == MAX) && (j_q == MAX) && (k_q == MAX);

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - address/strobe sequencer for a DIM x DIM matrix multiply
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DIM    = DEFAULT_DIM,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [1:0]        status,
  output logic              done
);

  localparam int                IDX_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(DIM - 1);
  localparam logic [ADDR_W-1:0] DIM_A  = ADDR_W'(DIM);

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic              rd_en_q, rd_en_d;
  logic              mac_en_q, mac_en_d;
  logic              mac_clr_q, mac_clr_d;
  logic              mac_last_q, mac_last_d;
  logic [ADDR_W-1:0] mac_caddr_q, mac_caddr_d;
  logic              c_we_q, c_we_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;

  logic [IDX_W-1:0]  i_idx, j_idx, k_idx;
  logic              idx_last, idx_en, idx_clr;

  matmul_index_counter #(.DIM(DIM), .IDX_W(IDX_W)) u_idx (
    .clock  (clock),
    .rst_n  (rst_n),
    .clr_i  (idx_clr),
    .en_i   (idx_en),
    .i_o    (i_idx),
    .j_o    (j_idx),
    .k_o    (k_idx),
    .last_o (idx_last)
  );

  // The counter always holds the index of the read presented this cycle.
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    idx_en  = 1'b0;
    idx_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_clr = 1'b1;
        end else begin
          idx_en = 1'b1;
          if (idx_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_clr = 1'b1;
        end else if (drain_q) begin
          state_d = ST_COMPLETE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_COMPLETE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Two-stage strobe pipeline; abort kills anything still in flight.
  always_comb begin
    rd_en_d     = (state_d == ST_RUN);
    mac_en_d    = rd_en_q && !abort;
    mac_clr_d   = mac_en_d && (k_idx == '0);
    mac_last_d  = mac_en_d && (k_idx == K_LAST);
    mac_caddr_d = ADDR_W'(i_idx) * DIM_A + ADDR_W'(j_idx);
    c_we_d      = mac_last_q && !abort;
    c_addr_d    = c_we_d ? mac_caddr_q : '0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_caddr_q <= '0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      rd_en_q     <= rd_en_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_last_q  <= mac_last_d;
      mac_caddr_q <= mac_caddr_d;
      c_we_q      <= c_we_d;
      c_addr_q    <= c_addr_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign a_addr  = ADDR_W'(i_idx) * DIM_A + ADDR_W'(k_idx);
  assign b_addr  = ADDR_W'(k_idx) * DIM_A + ADDR_W'(j_idx);
  assign mac_en  = mac_en_q;
  assign mac_clr = mac_clr_q;
  assign c_we    = c_we_q;
  assign c_addr  = c_addr_q;
  assign status  = state_q;
  assign done    = (state_q == ST_COMPLETE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - randomized model-checked bench driving DIM=2 and DIM=4 sequencers
module tb_matmul_sequencer;

  localparam int AW = 8;

  logic clock = 1'b0;
  logic rst_n, start, abort;

  logic          rd_en_w[2], mac_en_w[2], mac_clr_w[2], c_we_w[2], done_w[2];
  logic [AW-1:0] a_addr_w[2], b_addr_w[2], c_addr_w[2];
  logic [1:0]    status_w[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  matmul_sequencer #(.DIM(2), .ADDR_W(AW)) dut0 (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_en(rd_en_w[0]), .a_addr(a_addr_w[0]), .b_addr(b_addr_w[0]),
    .mac_en(mac_en_w[0]), .mac_clr(mac_clr_w[0]), .c_we(c_we_w[0]),
    .c_addr(c_addr_w[0]), .status(status_w[0]), .done(done_w[0])
  );

  matmul_sequencer #(.DIM(4), .ADDR_W(AW)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_en(rd_en_w[1]), .a_addr(a_addr_w[1]), .b_addr(b_addr_w[1]),
    .mac_en(mac_en_w[1]), .mac_clr(mac_clr_w[1]), .c_we(c_we_w[1]),
    .c_addr(c_addr_w[1]), .status(status_w[1]), .done(done_w[1])
  );

  task automatic chk(input string name, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int d);
    chk({tag, "_rd_en"},  d, int'(rd_en_w[d]),   0);
    chk({tag, "_mac_en"}, d, int'(mac_en_w[d]),  0);
    chk({tag, "_c_we"},   d, int'(c_we_w[d]),    0);
    chk({tag, "_status"}, d, int'(status_w[d]),  0);
    chk({tag, "_done"},   d, int'(done_w[d]),    0);
    chk({tag, "_a_addr"}, d, int'(a_addr_w[d]),  0);
    chk({tag, "_b_addr"}, d, int'(b_addr_w[d]),  0);
    chk({tag, "_c_addr"}, d, int'(c_addr_w[d]),  0);
  endtask

  // Expected outputs t cycles after acceptance (mode: 0 idle, 1 running, 2 complete).
  typedef struct {
    int rd_en, a, b, mac_en, mac_clr, c_we, c_addr, status, done;
  } exp_t;

  function automatic exp_t predict(input int dim, input int mode, input int t);
    exp_t e;
    int   n;
    int   r;
    n = dim * dim * dim;
    e = '{default: 0};
    if (mode == 2) begin
      e.status = 3;
      e.done   = 1;
    end else if (mode == 1) begin
      e.status = (t <= n) ? 1 : 2;
      if (t <= n) begin
        r       = t - 1;
        e.rd_en = 1;
        e.a     = (r / (dim * dim)) * dim + r % dim;
        e.b     = (r % dim) * dim + (r / dim) % dim;
      end
      if (t >= 2 && t <= n + 1) begin
        e.mac_en  = 1;
        e.mac_clr = ((t - 2) % dim == 0) ? 1 : 0;
      end
      if (t >= dim + 2 && (t - 2) % dim == 0) begin
        e.c_we   = 1;
        e.c_addr = (t - 2) / dim - 1;
      end
    end
    return e;
  endfunction

  int mode[2] = '{0, 0};
  int tt[2]   = '{0, 0};

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      automatic int   dim = (d == 0) ? 2 : 4;
      automatic exp_t e;
      e = rst_n ? predict(dim, mode[d], tt[d]) : '{default: 0};
      chk("m_rd_en",   d, int'(rd_en_w[d]),   e.rd_en);
      chk("m_mac_en",  d, int'(mac_en_w[d]),  e.mac_en);
      chk("m_mac_clr", d, int'(mac_clr_w[d]), e.mac_clr);
      chk("m_c_we",    d, int'(c_we_w[d]),    e.c_we);
      chk("m_status",  d, int'(status_w[d]),  e.status);
      chk("m_done",    d, int'(done_w[d]),    e.done);
      if (e.rd_en == 1 || !rst_n) begin
        chk("m_a_addr", d, int'(a_addr_w[d]), e.a);
        chk("m_b_addr", d, int'(b_addr_w[d]), e.b);
      end
      if (e.c_we == 1 || !rst_n) chk("m_c_addr", d, int'(c_addr_w[d]), e.c_addr);
      if (!rst_n) begin
        mode[d] = 0;
        tt[d]   = 0;
      end else begin
        case (mode[d])
          0: if (start && !abort) begin mode[d] = 1; tt[d] = 1; end
          1: begin
            if (abort) mode[d] = 0;
            else if (tt[d] == dim * dim * dim + 2) mode[d] = 2;
            else tt[d] = tt[d] + 1;
          end
          default: if (!start) mode[d] = 0;
        endcase
      end
    end
  end

  initial begin
    int a_tab[8];
    int b_tab[8];
    int rd4, we4, last_we4, last_caddr4;
    a_tab = '{0, 1, 0, 1, 2, 3, 2, 3};
    b_tab = '{0, 2, 1, 3, 0, 2, 1, 3};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk_zero("reset", 0);
    chk_zero("reset", 1);

    // Cycle 0: reset released with start already high.
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    rd4 = 0; we4 = 0; last_we4 = -1; last_caddr4 = -1;
    for (int c = 1; c <= 82; c++) begin
      @(posedge clock);
      #1;
      start = (c != 71);
      abort = (c == 77 || c == 78);
      #1;
      if (c <= 12) begin
        chk("lit_rd_en", 0, int'(rd_en_w[0]), int'(c <= 8));
        if (c <= 8) begin
          chk("lit_a_addr", 0, int'(a_addr_w[0]), a_tab[c-1]);
          chk("lit_b_addr", 0, int'(b_addr_w[0]), b_tab[c-1]);
        end
        chk("lit_mac_clr", 0, int'(mac_clr_w[0]), int'(c == 2 || c == 4 || c == 6 || c == 8));
        chk("lit_c_we", 0, int'(c_we_w[0]), int'(c == 4 || c == 6 || c == 8 || c == 10));
        if (c == 4 || c == 6 || c == 8 || c == 10)
          chk("lit_c_addr", 0, int'(c_addr_w[0]), (c - 4) / 2);
      end
      if (c >= 11 && c <= 70) chk("lit_done_held", 0, int'(done_w[0]), 1);
      if (c <= 70) begin
        rd4 += int'(rd_en_w[1]);
        if (c_we_w[1]) begin
          we4++;
          last_we4    = c;
          last_caddr4 = int'(c_addr_w[1]);
        end
      end
      if (c == 67) chk("lit_status_complete", 1, int'(status_w[1]), 3);
      if (c == 73) begin
        chk("lit_rerun_rd_en", 0, int'(rd_en_w[0]), 1);
        chk("lit_rerun_rd_en", 1, int'(rd_en_w[1]), 1);
        chk("lit_rerun_a_addr", 0, int'(a_addr_w[0]), 0);
      end
      if (c == 78 || c == 79) begin
        chk("lit_abort_status", 0, int'(status_w[0]), 0);
        chk("lit_abort_rd_en", 0, int'(rd_en_w[0]), 0);
        chk("lit_abort_mac_en", 0, int'(mac_en_w[0]), 0);
        chk("lit_abort_c_we", 0, int'(c_we_w[0]), 0);
      end
      if (c == 80) begin
        chk("lit_restart_rd_en", 0, int'(rd_en_w[0]), 1);
        chk("lit_restart_a_addr", 0, int'(a_addr_w[0]), 0);
        chk("lit_restart_b_addr", 0, int'(b_addr_w[0]), 0);
      end
    end
    chk("lit_rd_count", 1, rd4, 64);
    chk("lit_we_count", 1, we4, 16);
    chk("lit_last_we_cycle", 1, last_we4, 66);
    chk("lit_last_c_addr", 1, last_caddr4, 15);

    abort = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock);
      #1;
      if ($urandom_range(0, 7) == 0) start = ~start;
      abort = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst", 0);
        chk_zero("async_rst", 1);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
